// File: rtl/rtc_escritura.sv
// Write-cycle sequencer for a multiplexed-AD RTC bus: an address phase and a data phase,
// each split into an active strobe half and a release/hold half of T_FASE cycles.
module rtc_escritura #(
  parameter int T_FASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [7:0] direccion,
  input  logic [7:0] dato,
  output logic       cs_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] bus_sal,
  output logic       bus_oe,
  output logic       ocupado,
  output logic       listo
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DIR_ACT = 3'd1;
  localparam logic [2:0] DIR_REL = 3'd2;
  localparam logic [2:0] DAT_ACT = 3'd3;
  localparam logic [2:0] DAT_REL = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  localparam logic [7:0] RECARGA = 8'(T_FASE - 1);

  logic [2:0] estado_reg, estado_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] dir_reg, dir_next;
  logic [7:0] dat_reg, dat_next;

  always_comb begin
    estado_next = estado_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    dat_next    = dat_reg;
    case (estado_reg)
      IDLE: begin
        if (inicio) begin
          dir_next    = direccion;
          dat_next    = dato;
          cnt_next    = RECARGA;
          estado_next = DIR_ACT;
        end
      end
      DIR_ACT, DIR_REL, DAT_ACT, DAT_REL: begin
        if (cnt_reg == 8'd0) begin
          cnt_next    = RECARGA;
          estado_next = (estado_reg == DAT_REL) ? FIN : estado_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      FIN:     estado_next = IDLE;
      default: estado_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_reg <= IDLE;
      cnt_reg    <= 8'd0;
      dir_reg    <= 8'h00;
      dat_reg    <= 8'h00;
    end else begin
      estado_reg <= estado_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      dat_reg    <= dat_next;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      ad_n    <= 1'b1;
      bus_sal <= 8'h00;
      bus_oe  <= 1'b0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
    end else begin
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      ad_n    <= 1'b1;
      bus_sal <= 8'h00;
      bus_oe  <= 1'b0;
      ocupado <= (estado_next != IDLE);
      listo   <= 1'b0;
      case (estado_next)
        DIR_ACT: begin
          cs_n    <= 1'b0;
          wr_n    <= 1'b0;
          ad_n    <= 1'b0;
          bus_sal <= dir_next;
          bus_oe  <= 1'b1;
        end
        DIR_REL: begin
          ad_n    <= 1'b0;
          bus_sal <= dir_next;
          bus_oe  <= 1'b1;
        end
        DAT_ACT: begin
          cs_n    <= 1'b0;
          wr_n    <= 1'b0;
          bus_sal <= dat_next;
          bus_oe  <= 1'b1;
        end
        DAT_REL: begin
          bus_sal <= dat_next;
          bus_oe  <= 1'b1;
        end
        FIN:     listo <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_escritura.sv
// Scoreboarded bench: two instances (T_FASE=4 and T_FASE=1) share stimulus; a timeline model
// predicts each cycle's outputs from the cycle offset since acceptance.
module tb_rtc_escritura;

  typedef struct packed {
    logic       cs;
    logic       wr;
    logic       ad;
    logic       oe;
    logic       oc;
    logic       li;
    logic [7:0] bus;
    logic       chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicio = 1'b0;
  logic [7:0] direccion = 8'h00;
  logic [7:0] dato = 8'h00;

  logic       cs4, wr4, ad4, oe4, oc4, li4;
  logic [7:0] bus4;
  logic       cs1, wr1, ad1, oe1, oc1, li1;
  logic [7:0] bus1;

  int compared = 0;
  int mismatched = 0;
  bit stim_done = 1'b0;

  exp_t q4[$];
  exp_t q1[$];

  bit         act4 = 1'b0, act1 = 1'b0;
  int         k4 = 0, k1 = 0;
  logic [7:0] a4 = 8'h00, d4 = 8'h00, a1 = 8'h00, d1 = 8'h00;

  always #5 clk = ~clk;

  rtc_escritura #(.T_FASE(4)) dut4 (
    .clk(clk), .reset(reset), .inicio(inicio), .direccion(direccion), .dato(dato),
    .cs_n(cs4), .wr_n(wr4), .ad_n(ad4), .bus_sal(bus4), .bus_oe(oe4),
    .ocupado(oc4), .listo(li4)
  );

  rtc_escritura #(.T_FASE(1)) dut1 (
    .clk(clk), .reset(reset), .inicio(inicio), .direccion(direccion), .dato(dato),
    .cs_n(cs1), .wr_n(wr1), .ad_n(ad1), .bus_sal(bus1), .bus_oe(oe1),
    .ocupado(oc1), .listo(li1)
  );

  // Expected outputs for offset k (1..4T+1) since acceptance; act=0 means idle.
  function automatic exp_t predict(input int t, input bit act, input int k,
                                   input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int   p;
    e = '{cs: 1'b1, wr: 1'b1, ad: 1'b1, oe: 1'b0, oc: 1'b0, li: 1'b0, bus: 8'h00, chk: 1'b1};
    if (act) begin
      e.oc = 1'b1;
      if (k == 4 * t + 1) begin
        e.li  = 1'b1;
        e.chk = 1'b0;
      end else begin
        p     = (k - 1) / t;
        e.cs  = (p == 1 || p == 3);
        e.wr  = e.cs;
        e.ad  = (p >= 2);
        e.oe  = 1'b1;
        e.bus = (p < 2) ? a : d;
      end
    end
    return e;
  endfunction

  task automatic step(input int t, inout bit act, inout int k,
                      inout logic [7:0] a, inout logic [7:0] d);
    if (!reset) begin
      act = 1'b0;
      a   = 8'h00;
      d   = 8'h00;
    end else if (act) begin
      if (k == 4 * t + 1) act = 1'b0;
      else k = k + 1;
    end else if (inicio) begin
      act = 1'b1;
      k   = 1;
      a   = direccion;
      d   = dato;
    end
  endtask

  task automatic cyc(input bit r, input bit ini, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    reset     = r;
    inicio    = ini;
    direccion = a;
    dato      = d;
    step(4, act4, k4, a4, d4);
    step(1, act1, k1, a1, d1);
    q4.push_back(predict(4, act4, k4, a4, d4));
    q1.push_back(predict(1, act1, k1, a1, d1));
  endtask

  task automatic check(input string nm, input exp_t e, input exp_t g);
    compared++;
    if (g.cs !== e.cs || g.wr !== e.wr || g.ad !== e.ad || g.oe !== e.oe ||
        g.oc !== e.oc || g.li !== e.li || (e.chk && g.bus !== e.bus) || g.cs !== g.wr) begin
      mismatched++;
      $display("FAIL %s t=%0t got cs=%b wr=%b ad=%b oe=%b oc=%b li=%b bus=%h exp cs=%b wr=%b ad=%b oe=%b oc=%b li=%b bus=%h(chk=%b)",
               nm, $time, g.cs, g.wr, g.ad, g.oe, g.oc, g.li, g.bus,
               e.cs, e.wr, e.ad, e.oe, e.oc, e.li, e.bus, e.chk);
    end else begin
      $display("ok %s t=%0t cs=%b ad=%b oe=%b oc=%b li=%b bus=%h", nm, $time,
               g.cs, g.ad, g.oe, g.oc, g.li, g.bus);
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        g = '{cs: cs4, wr: wr4, ad: ad4, oe: oe4, oc: oc4, li: li4, bus: bus4, chk: 1'b1};
        check("t4", e, g);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        g = '{cs: cs1, wr: wr1, ad: ad1, oe: oe1, oc: oc1, li: li1, bus: bus1, chk: 1'b1};
        check("t1", e, g);
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hFF, 8'hFF);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00);
    // Single 0x21/0x59 write; address input changes to 0x33 mid-cycle.
    cyc(1'b1, 1'b1, 8'h21, 8'h59);
    for (int i = 1; i <= 22; i++) cyc(1'b1, 1'b0, (i >= 3) ? 8'h33 : 8'h21, 8'h59);
    cyc(1'b1, 1'b1, 8'hF0, 8'hAA);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00);
    // Held start request for 40 cycles.
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 8'(i), 8'(8'hC0 + i));
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00);
    // Ignored pulse at cycle 5, then reset during cycle 10, then a normal write.
    cyc(1'b1, 1'b1, 8'h12, 8'h34);
    for (int i = 1; i <= 22; i++) cyc(1'b1, (i == 5), 8'h56, 8'h78);
    cyc(1'b1, 1'b1, 8'h9A, 8'hBC);
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 8'hDE, 8'hAD);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
          8'($urandom), 8'($urandom));
    stim_done = 1'b1;
  end

  initial begin : finisher
    wait (stim_done);
    repeat (2) @(posedge clk);
    #2;
    compared++;
    if (q4.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain got q4=%0d q1=%0d expected 0 0", q4.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
